// File: rtl/cmd_uart_tx.sv
// Return-path UART transmitter: queues 32-bit words in a small FIFO and sends
// each one as four 8N1 bytes, most-significant byte first.
module cmd_uart_tx #(
  parameter int FREQ_HZ    = 25_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic        word_axis_tvalid_i,
  output logic        word_axis_tready_o,
  input  logic [31:0] word_axis_tdata_i,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int CLKS_PER_BIT = FREQ_HZ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [31:0]   shift_reg;
  logic [7:0]    cur_byte;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [31:0]   head_word;
  logic          empty, empty_nxt, full_nxt;
  logic          push, pop, bit_done, word_done, going_idle;

  assign empty      = (wr_ptr == rd_ptr);
  assign head_word  = mem[rd_ptr[AW-1:0]];
  assign cur_byte   = shift_reg[31:24];
  assign push       = word_axis_tvalid_i && word_axis_tready_o && !reset;
  assign bit_done   = (baud_cnt == CNT_LAST);
  assign word_done  = (state == STOP) && bit_done && (byte_idx == 2'd3);
  assign pop        = !empty && ((state == IDLE) || word_done);
  assign going_idle = empty && ((state == IDLE) || word_done);
  assign wr_ptr_nxt = wr_ptr + PW'(push);
  assign rd_ptr_nxt = rd_ptr + PW'(pop);
  assign empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
  assign full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

  always_ff @(posedge clk_pix) begin
    if (push) mem[wr_ptr[AW-1:0]] <= word_axis_tdata_i;
  end

  // Ready is registered from the post-edge occupancy, so a pop never reaches it combinationally.
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      word_axis_tready_o <= 1'b0;
    end else begin
      wr_ptr             <= wr_ptr_nxt;
      rd_ptr             <= rd_ptr_nxt;
      word_axis_tready_o <= !full_nxt;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
      tx_o      <= 1'b1;
      busy_o    <= 1'b0;
    end else begin
      busy_o <= !empty_nxt || !going_idle;

      // The line level follows the state one cycle later, giving pop-then-start latency.
      unique case (state)
        START:   tx_o <= 1'b0;
        DATA:    tx_o <= cur_byte[bit_idx];
        default: tx_o <= 1'b1;
      endcase

      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shift_reg <= head_word;
            byte_idx  <= 2'd0;
            state     <= START;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (byte_idx != 2'd3) begin
              byte_idx  <= byte_idx + 2'd1;
              shift_reg <= {shift_reg[23:0], 8'h00};
              state     <= START;
            end else if (pop) begin
              shift_reg <= head_word;
              byte_idx  <= 2'd0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_uart_tx.sv
// Bench for cmd_uart_tx: two instances (10 and 217 clocks per bit) whose serial
// lines are decoded sample-by-sample against a queue of expected bytes.
module tb_cmd_uart_tx;

  localparam int CPB_A = 10;
  localparam int CPB_B = 217;

  logic        clk_pix = 1'b0;
  logic        reset   = 1'b1;
  logic        tvalid_a = 1'b0, tvalid_b = 1'b0;
  logic [31:0] tdata_a = '0, tdata_b = '0;
  logic        tready_a, tready_b, tx_a, tx_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_a[$], exp_b[$], got_a[$];
  int acc_a[$], acc_b[$], start_a[$], end_a[$], start_b[$], end_b[$];

  always #5 clk_pix = ~clk_pix;
  always @(posedge clk_pix) cyc <= cyc + 1;

  cmd_uart_tx #(.FREQ_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4)) dut_a (
    .clk_pix(clk_pix), .reset(reset),
    .word_axis_tvalid_i(tvalid_a), .word_axis_tready_o(tready_a),
    .word_axis_tdata_i(tdata_a), .tx_o(tx_a), .busy_o(busy_a)
  );

  cmd_uart_tx dut_b (
    .clk_pix(clk_pix), .reset(reset),
    .word_axis_tvalid_i(tvalid_b), .word_axis_tready_o(tready_b),
    .word_axis_tdata_i(tdata_b), .tx_o(tx_b), .busy_o(busy_b)
  );

  // Reference model: every accepted word becomes four bytes, MSB first; reset discards everything pending.
  always @(posedge clk_pix) begin
    if (reset) begin
      exp_a.delete();
      exp_b.delete();
    end else begin
      if (tvalid_a && tready_a) begin
        for (int i = 3; i >= 0; i--) exp_a.push_back(tdata_a[8*i +: 8]);
        acc_a.push_back(cyc + 1);
      end
      if (tvalid_b && tready_b) begin
        for (int i = 3; i >= 0; i--) exp_b.push_back(tdata_b[8*i +: 8]);
        acc_b.push_back(cyc + 1);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic lineBit(input int which);
    return (which == 0) ? tx_a : tx_b;
  endfunction

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic clearLogs();
    acc_a.delete(); acc_b.delete(); got_a.delete();
    start_a.delete(); end_a.delete(); start_b.delete(); end_b.delete();
  endtask

  // Decodes 8N1 frames: every one of the cpb samples of each bit must match its first sample.
  task automatic monitorLine(input int which, input int cpb);
    logic [9:0] first;
    logic [7:0] got, want;
    int  bad, t0;
    bit  aborted, have;
    forever begin
      @(negedge clk_pix);
      if (!reset && lineBit(which) === 1'b0) begin
        t0 = cyc; bad = 0; aborted = 0;
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < cpb; s++) begin
            if (b != 0 || s != 0) @(negedge clk_pix);
            if (reset) begin
              aborted = 1;
              break;
            end
            if (s == 0) first[b] = lineBit(which);
            else if (lineBit(which) !== first[b]) bad++;
          end
          if (aborted) break;
        end
        if (!aborted) begin
          got = first[8:1];
          checkOutput($sformatf("bit_width%0d", which), 32'(bad), 32'd0);
          checkOutput($sformatf("stop_bit%0d", which), 32'(first[9]), 32'd1);
          have = 0;
          want = '0;
          if (which == 0 && exp_a.size() > 0) begin have = 1; want = exp_a.pop_front(); end
          if (which == 1 && exp_b.size() > 0) begin have = 1; want = exp_b.pop_front(); end
          if (have) checkOutput($sformatf("byte%0d", which), 32'(got), 32'(want));
          else checkOutput($sformatf("extra_byte%0d", which), 32'(got), 32'h100);
          if (which == 0) begin start_a.push_back(t0); end_a.push_back(cyc); got_a.push_back(got); end
          else begin start_b.push_back(t0); end_b.push_back(cyc); end
        end
      end
    end
  endtask

  // Presents one word and holds it until accepted; keep leaves tvalid high for a follow-on word.
  task automatic applyStimulus(input int which, input logic [31:0] word, input bit keep);
    int n0, k;
    n0 = (which == 0) ? acc_a.size() : acc_b.size();
    if (which == 0) begin tvalid_a = 1'b1; tdata_a = word; end
    else begin tvalid_b = 1'b1; tdata_b = word; end
    k = 0;
    do begin
      tick();
      k++;
    end while (((which == 0) ? acc_a.size() : acc_b.size()) == n0 && k < 1000);
    checkOutput("accepted", 32'(((which == 0) ? acc_a.size() : acc_b.size()) - n0), 32'd1);
    if (!keep) begin
      if (which == 0) tvalid_a = 1'b0;
      else tvalid_b = 1'b0;
    end
  endtask

  task automatic waitIdle(input int which, input int limit);
    int k;
    k = 0;
    do begin
      @(negedge clk_pix);
      k++;
    end while (((which == 0) ? busy_a : busy_b) !== 1'b0 && k < limit);
    checkOutput($sformatf("idle%0d", which), 32'((which == 0) ? busy_a : busy_b), 32'd0);
    repeat (3) @(negedge clk_pix);
  endtask

  initial begin
    int first_low, k;
    fork
      monitorLine(0, CPB_A);
      monitorLine(1, CPB_B);
    join_none

    // Reset with a word offered: it must not be taken.
    tvalid_a = 1'b1;
    tdata_a  = 32'h55AA55AA;
    repeat (3) begin
      @(negedge clk_pix);
      checkOutput("rst_tx", 32'(tx_a), 32'd1);
      checkOutput("rst_busy", 32'(busy_a), 32'd0);
      checkOutput("rst_ready", 32'(tready_a), 32'd0);
    end
    tick();
    reset    = 1'b0;
    tvalid_a = 1'b0;
    tick();
    @(negedge clk_pix);
    checkOutput("ready_after_rst", 32'(tready_a), 32'd1);
    checkOutput("busy_after_rst", 32'(busy_a), 32'd0);
    checkOutput("tx_after_rst", 32'(tx_a), 32'd1);

    // Single word
    clearLogs();
    applyStimulus(0, 32'h12345678, 1'b0);
    waitIdle(0, 600);
    checkOutput("single_frames", 32'(start_a.size()), 32'd4);
    if (start_a.size() == 4 && acc_a.size() == 1) begin
      checkOutput("single_latency", 32'(start_a[0] - acc_a[0]), 32'd2);
      checkOutput("single_len", 32'(end_a[3] - start_a[0] + 1), 32'(40 * CPB_A));
    end
    checkOutput("single_tx_idle", 32'(tx_a), 32'd1);
    checkOutput("single_drained", 32'(exp_a.size()), 32'd0);

    // Back-to-back words
    clearLogs();
    applyStimulus(0, 32'hA5A5A5A5, 1'b1);
    applyStimulus(0, 32'h00FF00FF, 1'b0);
    waitIdle(0, 1200);
    checkOutput("b2b_frames", 32'(start_a.size()), 32'd8);
    if (start_a.size() == 8 && acc_a.size() == 2) begin
      checkOutput("b2b_consecutive", 32'(acc_a[1] - acc_a[0]), 32'd1);
      checkOutput("b2b_no_gap", 32'(start_a[4]), 32'(end_a[3] + 1));
      checkOutput("b2b_len", 32'(end_a[7] - start_a[0] + 1), 32'(80 * CPB_A));
    end

    // Backpressure: tvalid held, data counts accepted words
    clearLogs();
    first_low = -1;
    k = 0;
    tvalid_a = 1'b1;
    tdata_a  = 32'd0;
    while (acc_a.size() < 10 && k < 8000) begin
      tick();
      k++;
      if (!tready_a && first_low < 0) first_low = acc_a.size();
      tdata_a = 32'(acc_a.size());
    end
    tvalid_a = 1'b0;
    checkOutput("bp_accepted", 32'(acc_a.size()), 32'd10);
    checkOutput("bp_depth", 32'(first_low), 32'd5);
    waitIdle(0, 6000);
    checkOutput("bp_frames", 32'(start_a.size()), 32'd40);
    if (start_a.size() == 40 && acc_a.size() == 10) begin
      for (int i = 0; i < 5; i++)
        checkOutput($sformatf("bp_ready_after_pop%0d", i), 32'(acc_a[5+i]), 32'(start_a[4*(1+i)]));
    end
    checkOutput("bp_drained", 32'(exp_a.size()), 32'd0);

    // Bit order
    clearLogs();
    applyStimulus(0, 32'h01800000, 1'b0);
    waitIdle(0, 600);
    if (got_a.size() >= 2) begin
      checkOutput("order_b0", 32'(got_a[0]), 32'h01);
      checkOutput("order_b1", 32'(got_a[1]), 32'h80);
    end else begin
      checkOutput("order_frames", 32'(got_a.size()), 32'd4);
    end

    // Reset during the data bits of the second byte
    clearLogs();
    applyStimulus(0, 32'hCAFEF00D, 1'b1);
    applyStimulus(0, 32'h11111111, 1'b0);
    k = 0;
    while (got_a.size() < 1 && k < 500) begin
      @(negedge clk_pix);
      k++;
    end
    checkOutput("mid_first_byte", 32'(got_a.size()), 32'd1);
    repeat (35) tick();
    reset = 1'b1;
    @(posedge clk_pix);
    @(negedge clk_pix);
    checkOutput("mid_rst_tx", 32'(tx_a), 32'd1);
    checkOutput("mid_rst_busy", 32'(busy_a), 32'd0);
    checkOutput("mid_rst_ready", 32'(tready_a), 32'd0);
    tick();
    reset = 1'b0;
    clearLogs();
    applyStimulus(0, 32'hDEADBEEF, 1'b0);
    waitIdle(0, 600);
    checkOutput("post_rst_frames", 32'(got_a.size()), 32'd4);
    if (got_a.size() == 4)
      checkOutput("post_rst_word", {got_a[0], got_a[1], got_a[2], got_a[3]}, 32'hDEADBEEF);
    checkOutput("post_rst_drained", 32'(exp_a.size()), 32'd0);

    // Random words with random idle gaps and junk data while tvalid is low
    clearLogs();
    for (int w = 0; w < 8; w++) begin
      repeat ($urandom_range(0, 3)) begin
        tick();
        tdata_a = $urandom;
      end
      applyStimulus(0, $urandom, 1'b0);
    end
    waitIdle(0, 4000);
    checkOutput("rand_frames", 32'(got_a.size()), 32'd32);
    checkOutput("rand_drained", 32'(exp_a.size()), 32'd0);

    // Default parameters: 217 clocks per bit
    clearLogs();
    applyStimulus(1, $urandom, 1'b0);
    waitIdle(1, 10000);
    checkOutput("b_frames", 32'(start_b.size()), 32'd4);
    if (start_b.size() == 4)
      checkOutput("b_len", 32'(end_b[3] - start_b[0] + 1), 32'(40 * CPB_B));
    checkOutput("b_drained", 32'(exp_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_uart_tx.md
Name: cmd_uart_tx

Overview:
- Return-path transmitter for the host command link.
- Accepts 32-bit words on an AXI-stream-style input, for example status or readback words from graphite.
- Buffers them in a small FIFO and sends each word over UART 8N1 as 4 bytes, most-significant byte first.
- This is the same byte order the host uses when sending commands, so the host can reassemble words with identical framing.

Parameters:
FREQ_HZ, 25_000_000, clk_pix frequency in Hz.
BAUD, 115_200, line rate. CLKS_PER_BIT = FREQ_HZ / BAUD, integer division (default 217). Must be ≥ 2.
FIFO_DEPTH, 4, word FIFO depth. Power of 2, ≥ 2.

Ports:
clk_pix  input  1  pixel clock; all logic is on its rising edge.
reset  input  1  synchronous, active-high reset.
word_axis_tvalid_i  input  1  input word valid.
word_axis_tready_o  output  1  FIFO can accept a word.
word_axis_tdata_i  input  32  input word.
tx_o  output  1  UART serial out; idles high.
busy_o  output  1  FIFO non-empty or serializer not IDLE.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk_pix.
- Reset values:
  - tx_o = 1, busy_o = 0, word_axis_tready_o = 0 while reset is high.
  - word_axis_tready_o = 1 from the first cycle after reset deasserts.
  - FIFO is flushed and the serializer returns to IDLE.
- Handshake:
  - A word is transferred on an edge where tvalid_i && tready_o.
  - tready_o = !full, from registered FIFO state.
  - When full, tready_o stays 0 even if a pop occurs in the same cycle; no combinational pop-to-ready path.
  - tdata_i may change freely when no transfer occurs.
- FIFO: standard circular buffer with log2(FIFO_DEPTH)+1-bit pointers.
  - Full: pointer MSBs differ and the rest are equal.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the occupancy unchanged.
- Serializer states:
  - IDLE: if FIFO non-empty, pop the head word into a 32-bit shift register, set byte_idx = 0, go to START.
  - START: tx_o = 0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx = 0.
  - DATA: tx_o = current byte bit[bit_idx], LSB first, each bit for CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx_o = 1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx < 3: increment byte_idx, shift the word left by 8, go to START with no gap;
    - else if FIFO non-empty: pop the next word and go directly to START, giving back-to-back words with no idle bit;
    - else go to IDLE.
- Byte order: word[31:24], word[23:16], word[15:8], word[7:0].
- Timing:
  - One word occupies exactly 40 × CLKS_PER_BIT cycles on the line.
  - Latency: word accepted at edge t into an empty FIFO with the serializer IDLE → tx_o falls at edge t+2 (t+1 pops, t+2 enters START with tx_o registered low).
- Baud counter: counts 0..CLKS_PER_BIT−1 per bit and reloads on every state/bit boundary, so there is no cumulative drift.
- tx_o is a register output (glitch-free).
- busy_o is registered: 1 whenever the FIFO is non-empty or the state is not IDLE, as seen after the edge.
- Reset mid-frame: tx_o = 1 on the next edge, and a partially sent word is discarded. The host must treat a truncated frame as a framing error.
- Input words with tvalid_i asserted during reset are not accepted.

Test Plan:
- Common setup: FREQ_HZ = 1_000_000, BAUD = 100_000, giving CLKS_PER_BIT = 10.
- Single word: push 0x12345678 while idle → tx_o falls 2 edges later. Line decodes bytes 0x12, 0x34, 0x56, 0x78 with 8N1 framing and each bit exactly 10 cycles. Frame length is 400 cycles, then busy_o falls and tx_o stays 1.
- Back-to-back: push 0xA5A5A5A5 and 0x00FF00FF on consecutive cycles → 8 bytes A5 A5 A5 A5 00 FF 00 FF. The stop bit of byte 4 is followed immediately by the start bit of byte 5. Total 800 cycles.
- Full/backpressure: hold tvalid_i with incrementing data 0..9 → tready_o drops after the FIFO holds 4 words plus 1 in the shifter. Words are transmitted in order 0..9 with none lost or duplicated. tready_o returns exactly one cycle after each pop.
- Bit order: push 0x01800000 → first byte line bits after start are 1,0,0,0,0,0,0,0 (LSB first). The second byte (0x80) is 0,0,0,0,0,0,0,1.
- Reset mid-frame: assert reset during DATA of byte 2 → tx_o = 1, busy_o = 0 and tready_o = 0 on the next edge. After release, push 0xDEADBEEF → only DE AD BE EF is transmitted, with no remnant of the old word.
- Non-default BAUD: FREQ_HZ = 25_000_000 and BAUD = 115_200 → bit period measured at 217 cycles for every bit of a full word.
